ddr3_dfi_mem: RTL and testbench
===============================

Name: ddr3_dfi_mem

Overview:
- DFI-side responder (memory model): the target end of the DFI command/data interface driven by the DDR3 controller.
- Decodes DFI commands, tracks open rows in 8 banks, and stores write bursts into an internal synchronous RAM.
- Returns read bursts after a fixed latency and flags protocol violations.
- Used for controller simulation and FPGA loopback bring-up without a physical DDR3 device.

Parameters:
- DDR_ROW_BITS, 15, row address width
- DDR_COL_BITS, 10, column address width
- DDR_DQ_WIDTH, 16, DDR data width; PHY data width is 2*DDR_DQ_WIDTH
- DDR_DM_WIDTH, 2, DDR mask width; PHY mask width is 2*DDR_DM_WIDTH
- PHY_BURSTLEN, 4, PHY beats per RD/WR command (fixed at 4)
- RD_LATENCY, 3, cycles from RD command to first dfi_valid_o beat (minimum 2)
- MEM_ADDR_BITS, 10, log2 of RAM depth in PHY words

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous reset, active-high
- dfi_rst_ni  in  1  DDR reset, active-low
- dfi_cke_i  in  1  clock enable
- dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni  in  1 each  command strobes
- dfi_odt_i  in  1  ignored
- dfi_bank_i  in  3  bank address
- dfi_addr_i  in  DDR_ROW_BITS  row/column address; A10 = auto-precharge / precharge-all
- dfi_wren_i  in  1  write-data beat valid
- dfi_mask_i  in  2*DDR_DM_WIDTH  byte mask; 1 = byte not written
- dfi_data_i  in  2*DDR_DQ_WIDTH  write data
- dfi_rden_i  in  1  ignored (timing comes from RD_LATENCY)
- dfi_valid_o  out  1  read-data beat valid
- dfi_data_o  out  2*DDR_DQ_WIDTH  read data
- err_o  out  4  sticky error flags

Behaviour:
- Reset (async): dfi_valid_o=0, dfi_data_o=0, err_o=0, all banks closed, write and read pipelines empty. RAM contents are not reset.
- Commands are decoded only when dfi_rst_ni=1, dfi_cke_i=1 and dfi_cs_ni=0. dfi_rst_ni=0 also closes all banks and flushes pending write bursts.
- Decode of {ras,cas,we}_n:
  - 011 ACT: open bank, latch row.
  - 101 RD; 100 WR.
  - 010 PRE: close bank; A10=1 closes all banks.
  - 001 REF; 000 MRS; 110 ZQ; 111 NOP. MRS and ZQ are no-ops.
- Word address W = {bank, row[bank], col[CSB:3], beat[1:0]}, truncated to the low MEM_ADDR_BITS bits (aliasing is intended). col[2:0] is ignored.
- RD/WR with A10=1: the bank closes after the command is accepted.
- ACT to an open bank, or REF while any bank is open: set err_o[1]; the bank state is still updated (ACT re-latches the row).
- RD/WR to a closed bank: set err_o[0]; the command is dropped.
- Write path:
  - WR loads the base address into a 2-entry write-command FIFO.
  - Each dfi_wren_i beat writes dfi_data_i to W(head, beat), per-byte masked, then beat increments.
  - After 4 beats the FIFO entry is popped.
  - A wren beat with the FIFO empty sets err_o[2]; the data is discarded.
  - WR arriving with the FIFO full sets err_o[2]; the command is dropped.
  - A WR command and a wren beat in the same cycle are legal (push and write together).
- Read path:
  - RD enters a RD_LATENCY-2 stage delay line, then a 2-entry FIFO.
  - The burst engine pops the FIFO and issues 4 consecutive RAM reads. RAM has 1-cycle read latency, giving the first dfi_valid_o exactly RD_LATENCY cycles after RD.
  - Back-to-back RDs 4 cycles apart produce gapless valid beats.
  - RDs closer than 4 cycles queue; FIFO overflow sets err_o[3] and drops the command.
  - dfi_data_o holds its last value when dfi_valid_o=0.
- Read/write to the same word in the same cycle: the RAM returns old data (read-first).
- err_o bits clear only on reset.

Decomposition:
- Shared package ddr3_defs: command encodings (CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS, CMD_ZQ, CMD_NOP) and error bit indices.
- One sub-module, ddr3_dfi_bank_track: 8 open flags plus row registers, ACT/PRE/auto-precharge update, and the row lookup used for address generation.

Test Plan:
- ACT b2 row 0x15; WR b2 col 0x08; 4 wren beats of 0xA0..A3 (mask 0); RD b2 col 0x08 → valid for 4 cycles starting exactly RD_LATENCY cycles after RD, data A0,A1,A2,A3; err_o=0.
- Overwrite beat 1 with mask 4'b0011 and data 0xFFFFFFFF → readback beat1 = 0xFFFF00A1 (low two bytes kept).
- RD to b5 with no ACT → err_o[0]=1, no dfi_valid_o. ACT b2 twice → err_o[1]=1.
- Single wren beat with no prior WR → err_o[2]=1, RAM unchanged.
- Three RDs issued 2 cycles apart → first two bursts return gapless (8 valid beats), third dropped, err_o[3]=1.
- Reset asserted mid-burst → dfi_valid_o=0 immediately; after release, RD to b2 → err_o[0]=1 (banks were closed by reset).

Source files
------------

// File: rtl/ddr3_dfi_mem_pkg.sv
// Shared definitions for the DFI-side DDR3 memory model: command encodings,
// error flag positions and default geometry.
package ddr3_defs;

  typedef enum logic [2:0] {
    CMD_MRS = 3'b000,
    CMD_REF = 3'b001,
    CMD_PRE = 3'b010,
    CMD_ACT = 3'b011,
    CMD_WR  = 3'b100,
    CMD_RD  = 3'b101,
    CMD_ZQ  = 3'b110,
    CMD_NOP = 3'b111
  } cmd_e;

  localparam int unsigned ERR_CLOSED = 0;
  localparam int unsigned ERR_ACT    = 1;
  localparam int unsigned ERR_WR     = 2;
  localparam int unsigned ERR_RD     = 3;
  localparam int unsigned ERR_W      = 4;

  localparam int unsigned NUM_BANKS  = 8;
  localparam int unsigned BANK_W     = 3;
  localparam int unsigned A10_BIT    = 10;

  localparam int unsigned DEF_ROW_BITS = 15;
  localparam int unsigned DEF_DQ_WIDTH = 16;
  localparam int unsigned DEF_DM_WIDTH = 2;

endpackage

// File: rtl/ddr3_dfi_mem_if.sv
// DFI command/data bus between a DDR3 controller (master) and the memory
// model (slave).
interface ddr3_dfi_if
  import ddr3_defs::*;
#(
  parameter int unsigned ROW_BITS = DEF_ROW_BITS,
  parameter int unsigned DQ_WIDTH = DEF_DQ_WIDTH,
  parameter int unsigned DM_WIDTH = DEF_DM_WIDTH
) ();

  logic                    dfi_rst_ni;
  logic                    dfi_cke_i;
  logic                    dfi_cs_ni;
  logic                    dfi_ras_ni;
  logic                    dfi_cas_ni;
  logic                    dfi_we_ni;
  logic                    dfi_odt_i;
  logic [BANK_W-1:0]       dfi_bank_i;
  logic [ROW_BITS-1:0]     dfi_addr_i;
  logic                    dfi_wren_i;
  logic [2*DM_WIDTH-1:0]   dfi_mask_i;
  logic [2*DQ_WIDTH-1:0]   dfi_data_i;
  logic                    dfi_rden_i;
  logic                    dfi_valid_o;
  logic [2*DQ_WIDTH-1:0]   dfi_data_o;

  modport master (
    output dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni,
    output dfi_odt_i, dfi_bank_i, dfi_addr_i, dfi_wren_i, dfi_mask_i,
    output dfi_data_i, dfi_rden_i,
    input  dfi_valid_o, dfi_data_o
  );

  modport slave (
    input  dfi_rst_ni, dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni,
    input  dfi_odt_i, dfi_bank_i, dfi_addr_i, dfi_wren_i, dfi_mask_i,
    input  dfi_data_i, dfi_rden_i,
    output dfi_valid_o, dfi_data_o
  );

endinterface

// File: rtl/ddr3_dfi_bank_track.sv
// Per-bank open flag and active row registers, with a combinational row
// lookup for the addressed bank.
module ddr3_dfi_bank_track
  import ddr3_defs::*;
#(
  parameter int unsigned ROW_BITS = DEF_ROW_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 act_i,
  input  logic                 close_i,
  input  logic                 close_all_i,
  input  logic [BANK_W-1:0]    bank_i,
  input  logic [ROW_BITS-1:0]  row_i,
  output logic [NUM_BANKS-1:0] open_o,
  output logic [ROW_BITS-1:0]  lookup_row_c_o
);

  logic [NUM_BANKS-1:0]               open_q;
  logic [NUM_BANKS-1:0][ROW_BITS-1:0] row_q;

  // ACT re-latches the row even when the bank is already open
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      open_q <= '0;
      row_q  <= '0;
    end else if (clr_i) begin
      open_q <= '0;
    end else if (act_i) begin
      open_q[bank_i] <= 1'b1;
      row_q[bank_i]  <= row_i;
    end else if (close_all_i) begin
      open_q <= '0;
    end else if (close_i) begin
      open_q[bank_i] <= 1'b0;
    end
  end

  assign open_o         = open_q;
  assign lookup_row_c_o = row_q[bank_i];

endmodule

// File: rtl/ddr3_dfi_mem.sv
// DFI-side DDR3 memory model: decodes controller commands, stores write
// bursts in a synchronous RAM and returns read bursts after a fixed latency.
module ddr3_dfi_mem
  import ddr3_defs::*;
#(
  parameter int unsigned DDR_ROW_BITS  = 15,
  parameter int unsigned DDR_COL_BITS  = 10,
  parameter int unsigned DDR_DQ_WIDTH  = 16,
  parameter int unsigned DDR_DM_WIDTH  = 2,
  parameter int unsigned PHY_BURSTLEN  = 4,
  parameter int unsigned RD_LATENCY    = 3,
  parameter int unsigned MEM_ADDR_BITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  ddr3_dfi_if.slave        dfi,
  output logic [ERR_W-1:0] err_o
);

  localparam int unsigned DQ_W      = 2 * DDR_DQ_WIDTH;
  localparam int unsigned DM_W      = 2 * DDR_DM_WIDTH;
  localparam int unsigned BYTE_W    = DQ_W / DM_W;
  localparam int unsigned BEAT_W    = $clog2(PHY_BURSTLEN);
  localparam int unsigned BASE_W    = MEM_ADDR_BITS - BEAT_W;
  localparam int unsigned FULL_W    = BANK_W + DDR_ROW_BITS + DDR_COL_BITS - 3;
  localparam int unsigned MEM_DEPTH = 1 << MEM_ADDR_BITS;
  localparam int unsigned DLY       = RD_LATENCY - 2;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(PHY_BURSTLEN - 1);

  // Command decode and bank state
  logic                      cmd_vld_c;
  cmd_e                      cmd_c;
  logic                      a10_c;
  logic                      sel_open_c;
  logic [NUM_BANKS-1:0]      bank_open;
  logic [DDR_ROW_BITS-1:0]   bank_row_c;
  logic [FULL_W-1:0]         full_addr_c;
  logic [BASE_W-1:0]         base_c;
  logic                      act_c, close_c, close_all_c, rd_ok_c, wr_ok_c;
  logic [ERR_W-1:0]          cmd_err_c;
  logic [ERR_W-1:0]          err_set_c;
  logic [ERR_W-1:0]          err_q;

  // Write command FIFO
  logic [1:0][BASE_W-1:0]    wq_base_q;
  logic                      wq_wptr_q, wq_rptr_q;
  logic [1:0]                wq_cnt_q;
  logic [BEAT_W-1:0]         wbeat_q;
  logic                      wq_full_c, wren_vld_c, wbeat_ok_c, wq_pop_c;
  logic [BASE_W-1:0]         wbase_c;
  logic [MEM_ADDR_BITS-1:0]  waddr_c;

  // Read delay line, FIFO and burst engine
  logic                      rdl_v_c;
  logic [BASE_W-1:0]         rdl_a_c;
  logic [1:0][BASE_W-1:0]    rq_base_q;
  logic                      rq_wptr_q, rq_rptr_q;
  logic [1:0]                rq_cnt_q;
  logic [BEAT_W-1:0]         rbeat_q;
  logic                      rq_full_c, rq_push_c, rq_pop_c, rd_en_c;
  logic [MEM_ADDR_BITS-1:0]  raddr_c;

  logic [DQ_W-1:0]           mem_q [MEM_DEPTH];
  logic                      valid_q;
  logic [DQ_W-1:0]           rdata_q;

  assign cmd_vld_c   = dfi.dfi_rst_ni & dfi.dfi_cke_i & ~dfi.dfi_cs_ni;
  assign cmd_c       = cmd_e'({dfi.dfi_ras_ni, dfi.dfi_cas_ni, dfi.dfi_we_ni});
  assign a10_c       = dfi.dfi_addr_i[A10_BIT];
  assign sel_open_c  = bank_open[dfi.dfi_bank_i];
  assign full_addr_c = {dfi.dfi_bank_i, bank_row_c, dfi.dfi_addr_i[DDR_COL_BITS-1:3]};
  assign base_c      = full_addr_c[BASE_W-1:0];

  always_comb begin
    act_c       = 1'b0;
    close_c     = 1'b0;
    close_all_c = 1'b0;
    rd_ok_c     = 1'b0;
    wr_ok_c     = 1'b0;
    cmd_err_c   = '0;
    if (cmd_vld_c) begin
      case (cmd_c)
        CMD_ACT: begin
          act_c              = 1'b1;
          cmd_err_c[ERR_ACT] = sel_open_c;
        end
        CMD_PRE: begin
          close_c     = 1'b1;
          close_all_c = a10_c;
        end
        CMD_REF: cmd_err_c[ERR_ACT] = |bank_open;
        CMD_RD: begin
          if (sel_open_c) begin
            rd_ok_c = 1'b1;
            close_c = a10_c;
          end else begin
            cmd_err_c[ERR_CLOSED] = 1'b1;
          end
        end
        CMD_WR: begin
          // A rejected WR has no side effects, including auto-precharge
          if (!sel_open_c) begin
            cmd_err_c[ERR_CLOSED] = 1'b1;
          end else if (wq_full_c) begin
            cmd_err_c[ERR_WR] = 1'b1;
          end else begin
            wr_ok_c = 1'b1;
            close_c = a10_c;
          end
        end
        default: ;
      endcase
    end
  end

  ddr3_dfi_bank_track #(
    .ROW_BITS (DDR_ROW_BITS)
  ) u_bank_track (
    .clk            (clk),
    .rst            (rst),
    .clr_i          (~dfi.dfi_rst_ni),
    .act_i          (act_c),
    .close_i        (close_c),
    .close_all_i    (close_all_c),
    .bank_i         (dfi.dfi_bank_i),
    .row_i          (dfi.dfi_addr_i),
    .open_o         (bank_open),
    .lookup_row_c_o (bank_row_c)
  );

  // Write path: a WR pushed this cycle can take a wren beat immediately
  assign wq_full_c  = (wq_cnt_q == 2'd2);
  assign wren_vld_c = dfi.dfi_wren_i & dfi.dfi_rst_ni;
  assign wbeat_ok_c = wren_vld_c & ((wq_cnt_q != 2'd0) | wr_ok_c);
  assign wbase_c    = (wq_cnt_q != 2'd0) ? wq_base_q[wq_rptr_q] : base_c;
  assign waddr_c    = {wbase_c, wbeat_q};
  assign wq_pop_c   = wbeat_ok_c & (wbeat_q == LAST_BEAT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wq_base_q <= '0;
      wq_wptr_q <= 1'b0;
      wq_rptr_q <= 1'b0;
      wq_cnt_q  <= 2'd0;
      wbeat_q   <= '0;
    end else if (!dfi.dfi_rst_ni) begin
      wq_wptr_q <= 1'b0;
      wq_rptr_q <= 1'b0;
      wq_cnt_q  <= 2'd0;
      wbeat_q   <= '0;
    end else begin
      if (wr_ok_c) begin
        wq_base_q[wq_wptr_q] <= base_c;
        wq_wptr_q            <= ~wq_wptr_q;
      end
      if (wq_pop_c) wq_rptr_q <= ~wq_rptr_q;
      if (wbeat_ok_c) wbeat_q <= wbeat_q + BEAT_W'(1);
      wq_cnt_q <= wq_cnt_q + 2'(wr_ok_c) - 2'(wq_pop_c);
    end
  end

  generate
    if (DLY == 0) begin : g_nodly
      assign rdl_v_c = rd_ok_c;
      assign rdl_a_c = base_c;
    end else begin : g_dly
      logic [DLY-1:0]             v_q;
      logic [DLY-1:0][BASE_W-1:0] a_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          v_q <= '0;
          a_q <= '0;
        end else begin
          v_q[0] <= rd_ok_c;
          a_q[0] <= base_c;
          for (int i = 1; i < int'(DLY); i++) begin
            v_q[i] <= v_q[i-1];
            a_q[i] <= a_q[i-1];
          end
        end
      end
      assign rdl_v_c = v_q[DLY-1];
      assign rdl_a_c = a_q[DLY-1];
    end
  endgenerate

  // The head entry stays queued until its last beat is issued
  assign rq_full_c = (rq_cnt_q == 2'd2);
  assign rq_push_c = rdl_v_c & ~rq_full_c;
  assign rd_en_c   = (rq_cnt_q != 2'd0);
  assign rq_pop_c  = rd_en_c & (rbeat_q == LAST_BEAT);
  assign raddr_c   = {rq_base_q[rq_rptr_q], rbeat_q};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rq_base_q <= '0;
      rq_wptr_q <= 1'b0;
      rq_rptr_q <= 1'b0;
      rq_cnt_q  <= 2'd0;
      rbeat_q   <= '0;
    end else begin
      if (rq_push_c) begin
        rq_base_q[rq_wptr_q] <= rdl_a_c;
        rq_wptr_q            <= ~rq_wptr_q;
      end
      if (rq_pop_c) rq_rptr_q <= ~rq_rptr_q;
      if (rd_en_c) rbeat_q <= rbeat_q + BEAT_W'(1);
      rq_cnt_q <= rq_cnt_q + 2'(rq_push_c) - 2'(rq_pop_c);
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(DM_W); b++) begin
      if (wbeat_ok_c && !dfi.dfi_mask_i[b]) begin
        mem_q[waddr_c][b*BYTE_W +: BYTE_W] <= dfi.dfi_data_i[b*BYTE_W +: BYTE_W];
      end
    end
  end

  // Read-first: a same-cycle write to raddr is not visible here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      valid_q <= rd_en_c;
      if (rd_en_c) rdata_q <= mem_q[raddr_c];
    end
  end

  always_comb begin
    err_set_c         = cmd_err_c;
    err_set_c[ERR_WR] = cmd_err_c[ERR_WR] | (wren_vld_c & ~wbeat_ok_c);
    err_set_c[ERR_RD] = rdl_v_c & rq_full_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_q <= '0;
    else     err_q <= err_q | err_set_c;
  end

  assign err_o           = err_q;
  assign dfi.dfi_valid_o = valid_q;
  assign dfi.dfi_data_o  = rdata_q;

  logic unused_c;
  assign unused_c = ^{dfi.dfi_odt_i, dfi.dfi_rden_i, full_addr_c[FULL_W-1:BASE_W]};

endmodule

// File: tb/tb_ddr3_dfi_mem.sv
// Scoreboard bench for ddr3_dfi_mem: directed DFI traffic, expected read
// beats queued with their arrival cycle and checked by a negedge monitor.
module tb_ddr3_dfi_mem;
  import ddr3_defs::*;

  localparam int unsigned RD_LAT = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] err;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    logic [31:0] d;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  ddr3_dfi_if #(.ROW_BITS(15), .DQ_WIDTH(16), .DM_WIDTH(2)) dfi_if ();

  ddr3_dfi_mem #(
    .DDR_ROW_BITS  (15),
    .DDR_COL_BITS  (10),
    .DDR_DQ_WIDTH  (16),
    .DDR_DM_WIDTH  (2),
    .PHY_BURSTLEN  (4),
    .RD_LATENCY    (RD_LAT),
    .MEM_ADDR_BITS (10)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .dfi   (dfi_if),
    .err_o (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every valid beat must match the queue head, data and cycle
  always @(negedge clk) begin
    exp_t e;
    if (dfi_if.dfi_valid_o) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got beat %h at cycle %0d want none", dfi_if.dfi_data_o, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", dfi_if.dfi_data_o, e.d);
        chk("rd_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_beat: got no valid by cycle %0d want %h at cycle %0d", cyc, e.d, e.cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a);
    dfi_if.dfi_cs_ni  = 1'b0;
    {dfi_if.dfi_ras_ni, dfi_if.dfi_cas_ni, dfi_if.dfi_we_ni} = c;
    dfi_if.dfi_bank_i = b;
    dfi_if.dfi_addr_i = a;
    step();
    dfi_if.dfi_cs_ni  = 1'b1;
    {dfi_if.dfi_ras_ni, dfi_if.dfi_cas_ni, dfi_if.dfi_we_ni} = 3'b111;
  endtask

  task automatic beat(input logic [31:0] d, input logic [3:0] m);
    dfi_if.dfi_wren_i = 1'b1;
    dfi_if.dfi_data_i = d;
    dfi_if.dfi_mask_i = m;
    step();
    dfi_if.dfi_wren_i = 1'b0;
  endtask

  // Issue RD and queue its four beats; extra delays a burst queued behind another
  task automatic rd(input logic [2:0] b, input logic [14:0] col, input logic [31:0] d [4], input int extra);
    for (int i = 0; i < 4; i++) exp_q.push_back('{d: d[i], cyc: cyc + int'(RD_LAT) + extra + i});
    cmd(CMD_RD, b, col);
  endtask

  logic [31:0] da [4];
  logic [31:0] dm [4];
  logic [31:0] db [4];

  initial begin
    da = '{32'h0000_00A0, 32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3};
    dm = '{32'h0000_00A0, 32'hFFFF_00A1, 32'h0000_00A2, 32'h0000_00A3};
    db = '{32'h0000_00B0, 32'h0000_00B1, 32'h0000_00B2, 32'h0000_00B3};
    dfi_if.dfi_rst_ni = 1'b0;
    dfi_if.dfi_cke_i  = 1'b0;
    dfi_if.dfi_cs_ni  = 1'b1;
    dfi_if.dfi_ras_ni = 1'b1;
    dfi_if.dfi_cas_ni = 1'b1;
    dfi_if.dfi_we_ni  = 1'b1;
    dfi_if.dfi_odt_i  = 1'b0;
    dfi_if.dfi_bank_i = '0;
    dfi_if.dfi_addr_i = '0;
    dfi_if.dfi_wren_i = 1'b0;
    dfi_if.dfi_mask_i = '0;
    dfi_if.dfi_data_i = '0;
    dfi_if.dfi_rden_i = 1'b0;

    repeat (3) step();
    chk("reset_valid", 32'(dfi_if.dfi_valid_o), 32'd0);
    chk("reset_data", dfi_if.dfi_data_o, 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    rst = 1'b0;
    dfi_if.dfi_rst_ni = 1'b1;
    dfi_if.dfi_cke_i  = 1'b1;
    step();

    // Basic write burst and readback
    cmd(CMD_ACT, 3'd2, 15'h0015);
    cmd(CMD_WR, 3'd2, 15'h0008);
    for (int i = 0; i < 4; i++) beat(da[i], 4'b0000);
    step();
    rd(3'd2, 15'h0008, da, 0);
    repeat (8) step();
    chk("err_after_basic", 32'(err), 32'h0);

    // Masked overwrite of beat 1, WR and first wren beat in the same cycle
    dfi_if.dfi_wren_i = 1'b1;
    dfi_if.dfi_data_i = 32'h1234_5678;
    dfi_if.dfi_mask_i = 4'b1111;
    cmd(CMD_WR, 3'd2, 15'h0008);
    beat(32'hFFFF_FFFF, 4'b0011);
    beat(32'h0BAD_0BAD, 4'b1111);
    beat(32'h0BAD_0BAD, 4'b1111);
    step();
    rd(3'd2, 15'h0008, dm, 0);
    repeat (8) step();
    chk("err_after_mask", 32'(err), 32'h0);

    // RD to a closed bank is dropped
    cmd(CMD_RD, 3'd5, 15'h0008);
    repeat (6) step();
    chk("err_rd_closed", 32'(err), 32'h1);

    cmd(CMD_ACT, 3'd2, 15'h0015);
    step();
    chk("err_act_open", 32'(err), 32'h3);

    // Orphan wren beat must not touch the RAM
    beat(32'hDEAD_BEEF, 4'b0000);
    step();
    chk("err_orphan_wren", 32'(err), 32'h7);
    rd(3'd2, 15'h0008, dm, 0);
    repeat (8) step();

    cmd(CMD_WR, 3'd2, 15'h0010);
    for (int i = 0; i < 4; i++) beat(db[i], 4'b0000);
    step();

    // Three RDs two cycles apart: two gapless bursts, third overflows
    rd(3'd2, 15'h0008, dm, 0);
    step();
    rd(3'd2, 15'h0010, db, 2);
    step();
    cmd(CMD_RD, 3'd2, 15'h0008);
    repeat (12) step();
    chk("err_rd_overflow", 32'(err), 32'hF);

    // Reset in the middle of a burst
    rd(3'd2, 15'h0008, dm, 0);
    repeat (4) step();
    chk("valid_before_rst", 32'(dfi_if.dfi_valid_o), 32'd1);
    rst = 1'b1;
    #1;
    chk("valid_in_rst", 32'(dfi_if.dfi_valid_o), 32'd0);
    chk("err_in_rst", 32'(err), 32'h0);
    exp_q.delete();
    repeat (2) step();
    rst = 1'b0;
    step();
    cmd(CMD_RD, 3'd2, 15'h0008);
    repeat (6) step();
    chk("err_rd_after_rst", 32'(err), 32'h1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t want finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
